// File: rtl/command_word_fifo_pkg.sv
// command_word_fifo_pkg: default geometry shared by command queue FIFO instances.
package command_word_fifo_pkg;
    localparam int c_default_width = 32;
    localparam int c_default_depth = 512;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM, one synchronous write port and one registered read port.
module fifo_ram #(
    parameter int c_width      = 32,
    parameter int c_depth      = 512,
    parameter int c_addr_width = $clog2(c_depth)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [c_addr_width-1:0] wr_addr,
    input  logic [c_width-1:0]      wr_data,
    input  logic                    rd_en,
    input  logic [c_addr_width-1:0] rd_addr,
    output logic [c_width-1:0]      rd_data
);
    logic [c_width-1:0] mem [c_depth];

    always_ff @(posedge clock)
        if (wr_en) mem[wr_addr] <= wr_data;

    // Output register clears on reset; the array itself is never cleared.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/command_word_fifo.sv
// command_word_fifo: single-clock FIFO with registered read data and exact full/empty flags.
module command_word_fifo
    import command_word_fifo_pkg::*;
#(
    parameter int c_width = c_default_width,
    parameter int c_depth = c_default_depth,
    localparam int c_addr_width = $clog2(c_depth)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wrreq,
    input  logic [c_width-1:0]    data,
    output logic                  wrfull,
    input  logic                  rdreq,
    output logic                  rdempty,
    output logic [c_width-1:0]    q,
    output logic [c_addr_width:0] usedw
);
    logic [1:0]              rst_pipe;
    logic                    rst_n_s;
    logic [c_addr_width-1:0] wr_ptr, rd_ptr;
    logic [c_addr_width:0]   count;
    logic                    wr_en, rd_en;

    // Reset asserts immediately and releases two clocks later, in step with clock.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) rst_pipe <= 2'b00;
        else rst_pipe <= {rst_pipe[0], 1'b1};

    assign rst_n_s = rst_pipe[1];
    assign wr_en   = wrreq && !wrfull;
    assign rd_en   = rdreq && !rdempty;
    assign rdempty = count == '0;
    assign wrfull  = count == (c_addr_width+1)'(c_depth);
    assign usedw   = count;

    always_ff @(posedge clock or negedge rst_n_s)
        if (!rst_n_s) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + c_addr_width'(1);
            if (rd_en) rd_ptr <= rd_ptr + c_addr_width'(1);
            if (wr_en && !rd_en) count <= count + (c_addr_width+1)'(1);
            else if (rd_en && !wr_en) count <= count - (c_addr_width+1)'(1);
        end

    fifo_ram #(
        .c_width(c_width),
        .c_depth(c_depth),
        .c_addr_width(c_addr_width)
    ) u_ram (
        .clock(clock),
        .reset_n(rst_n_s),
        .wr_en(wr_en),
        .wr_addr(wr_ptr),
        .wr_data(data),
        .rd_en(rd_en),
        .rd_addr(rd_ptr),
        .rd_data(q)
    );
endmodule

// File: tb/tb_command_word_fifo.sv
// tb_command_word_fifo: randomized and directed checks of 4-bit and 32-bit FIFO instances against a queue model.
module tb_command_word_fifo;
    localparam int depth = 512;

    logic        clock;
    logic        reset_n;
    logic        wrreq, rdreq;
    logic [31:0] data;
    logic        wrfull32, rdempty32, wrfull4, rdempty4;
    logic [31:0] q32;
    logic [3:0]  q4;
    logic [9:0]  usedw32, usedw4;

    int          checks = 0;
    int          failures = 0;
    int          step_no = 0;
    logic [31:0] mq[$];
    logic [31:0] qexp = '0;

    command_word_fifo #(.c_width(32)) dut32 (
        .clock(clock), .reset_n(reset_n), .wrreq(wrreq), .data(data),
        .wrfull(wrfull32), .rdreq(rdreq), .rdempty(rdempty32), .q(q32), .usedw(usedw32)
    );

    command_word_fifo #(.c_width(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .wrreq(wrreq), .data(data[3:0]),
        .wrfull(wrfull4), .rdreq(rdreq), .rdempty(rdempty4), .q(q4), .usedw(usedw4)
    );

    initial begin
        clock = 0;
        forever #10 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", tag, step_no, got, exp);
        end
    endtask

    task automatic check_all();
        check("usedw32", {22'b0, usedw32}, 32'(mq.size()));
        check("usedw4", {22'b0, usedw4}, 32'(mq.size()));
        check("rdempty32", {31'b0, rdempty32}, {31'b0, mq.size() == 0});
        check("rdempty4", {31'b0, rdempty4}, {31'b0, mq.size() == 0});
        check("wrfull32", {31'b0, wrfull32}, {31'b0, mq.size() == depth});
        check("wrfull4", {31'b0, wrfull4}, {31'b0, mq.size() == depth});
        check("q32", q32, qexp);
        check("q4", {28'b0, q4}, {28'b0, qexp[3:0]});
    endtask

    // One clock of stimulus; the model applies the accept rules to the pre-edge occupancy.
    task automatic step(input logic w, input logic r, input logic [31:0] d);
        bit we, re;
        wrreq = w;
        rdreq = r;
        data  = d;
        @(posedge clock);
        step_no++;
        we = w && mq.size() < depth;
        re = r && mq.size() > 0;
        if (re) qexp = mq.pop_front();
        if (we) mq.push_back(d);
        #1;
        check_all();
    endtask

    initial begin
        int reads;
        int written;
        wrreq = 0;
        rdreq = 0;
        data  = '0;
        reset_n = 0;
        #1000;
        check_all();
        @(negedge clock);
        reset_n = 1;
        repeat (3) step(0, 0, 0);

        step(1, 0, 2);
        check("rdempty_after_first_write", {31'b0, rdempty32}, 32'd0);
        step(1, 0, 3);
        step(1, 0, 0);
        step(1, 0, 0);
        check("usedw_four", {22'b0, usedw4}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0);
            step(0, 0, 0);
        end

        step(1, 0, 4);
        step(1, 0, 16);
        step(1, 0, 16);
        step(1, 0, 16);
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            if (!rdempty32) reads++;
            step(0, !rdempty32, 0);
        end
        check("reads_count", 32'(reads), 32'd4);

        for (int i = 0; i < depth; i++) step(1, 0, 32'(i));
        check("full_at_512", {31'b0, wrfull32}, 32'd1);
        step(1, 0, 32'hDEAD);
        check("usedw_overflow", {22'b0, usedw32}, 32'd512);
        for (int i = 0; i < depth; i++) step(0, 1, 0);
        step(0, 0, 0);

        step(0, 1, 0);
        step(1, 1, 32'h55);
        check("usedw_both_empty", {22'b0, usedw32}, 32'd1);
        for (int i = 0; i < 4; i++) step(1, 0, $urandom);
        step(1, 1, 32'hABCD1234);
        check("usedw_both_five", {22'b0, usedw32}, 32'd5);
        for (int i = 0; i < 6; i++) step(0, 1, 0);

        written = 0;
        for (int i = 0; i < 5000 && written < 1000; i++) begin
            logic w;
            w = ($urandom % 4) != 0 && mq.size() < depth - 1;
            if (w) written++;
            step(w, ($urandom % 2) == 1, $urandom);
        end
        check("stream_written", 32'(written), 32'd1000);
        while (mq.size() > 0 && step_no < 60000) step(0, 1, 0);

        for (int i = 0; i < 3; i++) step(1, 0, $urandom);
        step(0, 1, 0);
        #4;
        reset_n = 0;
        #1;
        mq.delete();
        qexp = '0;
        check_all();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        @(negedge clock);
        reset_n = 1;
        repeat (3) step(0, 0, 0);
        step(1, 0, 32'h77);
        step(0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
